pio_irq_ctrl: RTL and testbench
===============================

// Module: pio_irq_ctrl
// PURPOSE
//  Parametrised PIO IRQ flag controller. Holds the shared IRQ flags, executes state
//  machine IRQ SET/CLEAR/WAIT requests, and blocks waiting SMs until their flag is cleared.
//  Provides host read and write-1-to-clear access to the flags.
//  Masks flags[3:0] onto NUM_LINES system interrupt lines with per-line INTE/INTF/INTS.
//  Sits between the SM array and the host action decoder inside pio.
// PARAMETERS
//  NUM_SM     4  state machines served; 1..4
//  NUM_FLAGS  8  IRQ flags; fixed at 8, indexed by 3 bits
//  NUM_LINES  2  system IRQ outputs (irq0, irq1, ...); 1..4
// PORTS
//  clk           in   1            system clock
//  reset         in   1            asynchronous, active-low reset
//  sm_en         in   NUM_SM       SM enabled; 0 aborts any pending wait
//  sm_req        in   NUM_SM       one-cycle IRQ instruction strobe per SM
//  sm_op         in   2*NUM_SM     per SM: 0 SET, 1 CLEAR, 2 SET+WAIT, 3 reserved (ignored)
//  sm_idx        in   3*NUM_SM     per SM flag index
//  sm_rel        in   NUM_SM       relative indexing
//  sm_stall      out  NUM_SM       SM must not advance its PC
//  host_we       in   1            host write strobe
//  host_re       in   1            host read strobe
//  host_addr     in   2            0 FLAGS(W1C) 1 INTE 2 INTF 3 INTS(RO)
//  host_wdata    in   32           write data
//  host_rdata    out  32           read data, registered
//  flags         out  NUM_FLAGS    current flag register
//  irq_out       out  NUM_LINES    system interrupt lines, registered
// BEHAVIOUR
//  Reset: flags=0, inte=0, intf=0, host_rdata=0, irq_out=0, all SM FSMs IDLE, sm_stall=0.
//  Effective index: rel ? {idx[2], idx[1:0]+sm_id[1:0] (mod 4)} : idx.
//  Flag update each cycle:
//    next = (flags & ~clr_mask) | set_mask.
//    clr_mask = OR of SM CLEAR requests | (host_we && addr==0 ? wdata[7:0] : 0).
//    set_mask = OR of SM SET and SET+WAIT requests.
//    SET beats CLEAR on the same bit in the same cycle, from any source.
//  Per-SM FSM:
//    IDLE -> WAIT on sm_req && op==2 && sm_en; latch the effective index.
//    sm_stall = 1 in the request cycle (combinational) and throughout WAIT.
//    WAIT -> IDLE on the first cycle the registered flags[widx]==0;
//      sm_stall drops in that same cycle. Minimum stall is 2 cycles.
//    sm_en==0 in WAIT -> IDLE immediately. The flag is left untouched.
//  A SET+WAIT on a flag that is already set still enters WAIT; the set is a no-op.
//  sm_req while in WAIT is ignored; the SM is stalled and must not issue one.
//  Interrupt INTE/INTF register: 4 bits per line, packed at host_wdata[4*k+3:4*k].
//  ints[k] = (flags[3:0] | intf[k]) & inte[k].
//  irq_out[k] <= |ints[k]; latency is 1 cycle after the flag change.
//  Host reads: host_rdata <= selected register on host_re.
//    FLAGS is zero-extended; INTS is the packed ints.
//    A read takes effect 1 cycle after host_re.
//  A host write to INTS is ignored. A simultaneous host read and write at the same
//  address returns the pre-write value.
//  Mid-operation reset clears all flags and releases all stalls asynchronously.
// STRUCTURE
//  pio_pkg: IRQ_OP_SET/CLR/WAIT codes, host address constants, flag index width.
//  Sub-module pio_irq_wait: the per-SM IDLE/WAIT FSM plus relative-index adder,
//  instantiated NUM_SM times via generate.
//  Top level: flag register, set/clear reduction, INTE/INTF, line masking, host mux.
// TESTING
//  1. SM0 SET+WAIT idx0, SM1 SET+WAIT idx1 -> flags=0x03, both stalled 10 cycles.
//     With INTE0=0x7, irq_out[0]=1.
//  2. Host W1C 0x02 -> flags=0x01. SM1 stall drops within 1 cycle of the flag
//     clearing; SM0 stays stalled.
//  3. SM2 SET rel idx3 -> flags bit1 set (3+2 mod 4). Same-cycle host W1C bit1
//     -> bit1 stays set.
//  4. SM0 CLEAR idx5 and SM1 SET idx5 in one cycle -> flags[5]=1.
//     The next-cycle CLEAR -> flags[5]=0.
//  5. INTF1=0x8 with INTE1=0x8 and flags=0 -> irq_out[1]=1 after 1 cycle; INTS reads 0x80.
//  6. Assert reset mid-WAIT -> flags=0, sm_stall=0, irq_out=0 immediately.
//     sm_en drop in WAIT -> stall releases in the same cycle.

Source files
------------

// File: rtl/pio_pkg.sv
// pio_pkg
//   Shared definitions for the PIO IRQ flag controller: SM IRQ opcodes, host
//   register addresses, flag index width and the per-SM wait FSM states.
package pio_pkg;

  localparam int FLAG_IDX_W = 3;
  localparam int N_FLAGS    = 8;

  typedef enum logic [1:0] {
    IRQ_OP_SET  = 2'd0,
    IRQ_OP_CLR  = 2'd1,
    IRQ_OP_WAIT = 2'd2,
    IRQ_OP_RSVD = 2'd3
  } irq_op_e;

  localparam logic [1:0] HOST_ADDR_FLAGS = 2'd0;
  localparam logic [1:0] HOST_ADDR_INTE  = 2'd1;
  localparam logic [1:0] HOST_ADDR_INTF  = 2'd2;
  localparam logic [1:0] HOST_ADDR_INTS  = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } wait_state_e;

  function automatic logic [N_FLAGS-1:0] idx_to_mask(input logic [FLAG_IDX_W-1:0] idx);
    logic [N_FLAGS-1:0] m;
    m      = '0;
    m[idx] = 1'b1;
    return m;
  endfunction

endpackage

// File: rtl/pio_irq_wait.sv
// pio_irq_wait
//   Per-SM IRQ instruction handler: resolves the effective flag index
//   (relative indexing rotates the low two bits by the SM number), turns a
//   request into set/clear masks and holds the SM stalled while its
//   SET+WAIT flag stays set.
// Ports
//   clk, reset      clock, async active-low reset
//   sm_en           SM enabled; low aborts a pending wait
//   sm_req          one-cycle IRQ instruction strobe
//   sm_op, sm_idx   opcode and raw flag index
//   sm_rel          relative indexing
//   flags           registered flag vector from the top
//   set_mask        flags this SM sets this cycle
//   clr_mask        flags this SM clears this cycle
//   sm_stall        SM must hold its PC
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | no wait pending; stall only combinationally on a SET+WAIT
// ST_WAIT | stalled until flags[widx_q] reads 0 or the SM is disabled
module pio_irq_wait
  import pio_pkg::*;
#(
  parameter int SM_ID = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  sm_en,
  input  logic                  sm_req,
  input  logic [1:0]            sm_op,
  input  logic [FLAG_IDX_W-1:0] sm_idx,
  input  logic                  sm_rel,
  input  logic [N_FLAGS-1:0]    flags,
  output logic [N_FLAGS-1:0]    set_mask,
  output logic [N_FLAGS-1:0]    clr_mask,
  output logic                  sm_stall
);

  localparam logic [1:0] SM_OFS = 2'(SM_ID);

  wait_state_e           state_q, state_d;
  logic [FLAG_IDX_W-1:0] widx_q, widx_d;
  logic [FLAG_IDX_W-1:0] eff_idx;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      widx_q  <= '0;
    end else begin
      state_q <= state_d;
      widx_q  <= widx_d;
    end
  end

  always_comb begin
    eff_idx  = sm_rel ? {sm_idx[2], sm_idx[1:0] + SM_OFS} : sm_idx;
    state_d  = state_q;
    widx_d   = widx_q;
    set_mask = '0;
    clr_mask = '0;
    sm_stall = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sm_req) begin
          case (sm_op)
            IRQ_OP_SET: set_mask = idx_to_mask(eff_idx);
            IRQ_OP_CLR: clr_mask = idx_to_mask(eff_idx);
            IRQ_OP_WAIT: begin
              set_mask = idx_to_mask(eff_idx);
              if (sm_en) begin
                state_d  = ST_WAIT;
                widx_d   = eff_idx;
                sm_stall = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        // Release in the same cycle the registered flag reads clear.
        if (!sm_en || !flags[widx_q]) begin
          state_d = ST_IDLE;
        end else begin
          sm_stall = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/pio_irq_ctrl.sv
// pio_irq_ctrl
//   Shared PIO IRQ flag register with SM set/clear/wait handling, host
//   W1C/read access and masking of flags[3:0] onto system interrupt lines.
// Ports
//   clk, reset        clock, async active-low reset
//   sm_en/req/op/idx/rel   per-SM IRQ instruction inputs (packed per SM)
//   sm_stall          per-SM stall
//   host_we/re/addr/wdata  host access: 0 FLAGS(W1C) 1 INTE 2 INTF 3 INTS(RO)
//   host_rdata        registered read data
//   flags             current flag register
//   irq_out           registered system interrupt lines
module pio_irq_ctrl
  import pio_pkg::*;
#(
  parameter int NUM_SM    = 4,
  parameter int NUM_FLAGS = 8,
  parameter int NUM_LINES = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_SM-1:0]      sm_en,
  input  logic [NUM_SM-1:0]      sm_req,
  input  logic [2*NUM_SM-1:0]    sm_op,
  input  logic [3*NUM_SM-1:0]    sm_idx,
  input  logic [NUM_SM-1:0]      sm_rel,
  output logic [NUM_SM-1:0]      sm_stall,
  input  logic                   host_we,
  input  logic                   host_re,
  input  logic [1:0]             host_addr,
  input  logic [31:0]            host_wdata,
  output logic [31:0]            host_rdata,
  output logic [NUM_FLAGS-1:0]   flags,
  output logic [NUM_LINES-1:0]   irq_out
);

  localparam int INT_W = 4 * NUM_LINES;

  logic [NUM_FLAGS-1:0] flags_q, flags_d;
  logic [INT_W-1:0]     inte_q, inte_d;
  logic [INT_W-1:0]     intf_q, intf_d;
  logic [31:0]          rdata_q, rdata_d;
  logic [NUM_LINES-1:0] irq_q, irq_d;
  logic [INT_W-1:0]     ints;
  logic [NUM_FLAGS-1:0] set_mask, clr_mask;
  logic [NUM_FLAGS-1:0] sm_set [NUM_SM];
  logic [NUM_FLAGS-1:0] sm_clr [NUM_SM];
  logic                 wdata_unused;

  // Upper write-data bits are only meaningful for some NUM_LINES values.
  assign wdata_unused = ^host_wdata;

  for (genvar g = 0; g < NUM_SM; g++) begin : g_sm
    pio_irq_wait #(.SM_ID(g)) u_wait (
      .clk      (clk),
      .reset    (reset),
      .sm_en    (sm_en[g]),
      .sm_req   (sm_req[g]),
      .sm_op    (sm_op[2*g +: 2]),
      .sm_idx   (sm_idx[3*g +: 3]),
      .sm_rel   (sm_rel[g]),
      .flags    (flags_q),
      .set_mask (sm_set[g]),
      .clr_mask (sm_clr[g]),
      .sm_stall (sm_stall[g])
    );
  end

  always_comb begin
    set_mask = '0;
    clr_mask = '0;
    for (int i = 0; i < NUM_SM; i++) begin
      set_mask = set_mask | sm_set[i];
      clr_mask = clr_mask | sm_clr[i];
    end
    if (host_we && host_addr == HOST_ADDR_FLAGS) begin
      clr_mask = clr_mask | host_wdata[NUM_FLAGS-1:0];
    end
    // Set is applied last so it wins over any clear on the same bit.
    flags_d = (flags_q & ~clr_mask) | set_mask;
  end

  always_comb begin
    inte_d = inte_q;
    intf_d = intf_q;
    if (host_we && host_addr == HOST_ADDR_INTE) inte_d = host_wdata[INT_W-1:0];
    if (host_we && host_addr == HOST_ADDR_INTF) intf_d = host_wdata[INT_W-1:0];
  end

  always_comb begin
    ints  = '0;
    irq_d = '0;
    for (int k = 0; k < NUM_LINES; k++) begin
      ints[4*k +: 4] = (flags_q[3:0] | intf_q[4*k +: 4]) & inte_q[4*k +: 4];
      irq_d[k]       = |ints[4*k +: 4];
    end
  end

  // Reads use the registered values, so a same-cycle write is not yet visible.
  always_comb begin
    rdata_d = rdata_q;
    if (host_re) begin
      case (host_addr)
        HOST_ADDR_FLAGS: rdata_d = 32'(flags_q);
        HOST_ADDR_INTE:  rdata_d = 32'(inte_q);
        HOST_ADDR_INTF:  rdata_d = 32'(intf_q);
        default:         rdata_d = 32'(ints);
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flags_q <= '0;
      inte_q  <= '0;
      intf_q  <= '0;
      rdata_q <= '0;
      irq_q   <= '0;
    end else begin
      flags_q <= flags_d;
      inte_q  <= inte_d;
      intf_q  <= intf_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end

  assign flags      = flags_q;
  assign host_rdata = rdata_q;
  assign irq_out    = irq_q;

endmodule

// File: tb/tb_pio_irq_ctrl.sv
// tb_pio_irq_ctrl
//   Scoreboard bench for pio_irq_ctrl: each cycle's expectations are queued
//   while stimulus is driven and drained on the falling edge.
module tb_pio_irq_ctrl;

  localparam int NUM_SM    = 4;
  localparam int NUM_FLAGS = 8;
  localparam int NUM_LINES = 2;

  localparam int S_FLAGS = 0;
  localparam int S_STALL = 1;
  localparam int S_IRQ   = 2;
  localparam int S_RDATA = 3;

  localparam logic [1:0] OP_SET  = 2'd0;
  localparam logic [1:0] OP_CLR  = 2'd1;
  localparam logic [1:0] OP_WAIT = 2'd2;
  localparam logic [1:0] OP_RSVD = 2'd3;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [NUM_SM-1:0]    sm_en;
  logic [NUM_SM-1:0]    sm_req;
  logic [2*NUM_SM-1:0]  sm_op;
  logic [3*NUM_SM-1:0]  sm_idx;
  logic [NUM_SM-1:0]    sm_rel;
  logic [NUM_SM-1:0]    sm_stall;
  logic                 host_we;
  logic                 host_re;
  logic [1:0]           host_addr;
  logic [31:0]          host_wdata;
  logic [31:0]          host_rdata;
  logic [NUM_FLAGS-1:0] flags;
  logic [NUM_LINES-1:0] irq_out;

  pio_irq_ctrl #(
    .NUM_SM    (NUM_SM),
    .NUM_FLAGS (NUM_FLAGS),
    .NUM_LINES (NUM_LINES)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .sm_en      (sm_en),
    .sm_req     (sm_req),
    .sm_op      (sm_op),
    .sm_idx     (sm_idx),
    .sm_rel     (sm_rel),
    .sm_stall   (sm_stall),
    .host_we    (host_we),
    .host_re    (host_re),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .host_rdata (host_rdata),
    .flags      (flags),
    .irq_out    (irq_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] obs_sel(input int sel);
    case (sel)
      S_FLAGS: return 32'(flags);
      S_STALL: return 32'(sm_stall);
      S_IRQ:   return 32'(irq_out);
      default: return host_rdata;
    endcase
  endfunction

  task automatic push(input string tag, input int sel, input logic [31:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic drain(input bit at_neg);
    exp_t e;
    if (at_neg) @(negedge clk);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, obs_sel(e.sel), e.exp);
    end
  endtask

  task automatic tick();
    drain(1'b1);
    @(posedge clk);
    #1;
  endtask

  task automatic sm_cmd(input int s, input logic [1:0] op, input logic [2:0] idx, input logic rel);
    sm_req[s]        = 1'b1;
    sm_op[2*s +: 2]  = op;
    sm_idx[3*s +: 3] = idx;
    sm_rel[s]        = rel;
  endtask

  task automatic host_wr(input logic [1:0] addr, input logic [31:0] data);
    host_we    = 1'b1;
    host_addr  = addr;
    host_wdata = data;
  endtask

  task automatic host_rd(input logic [1:0] addr);
    host_re   = 1'b1;
    host_addr = addr;
  endtask

  task automatic idle_inputs();
    sm_req  = '0;
    host_we = 1'b0;
    host_re = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset      = 1'b0;
    sm_en      = '0;
    sm_req     = '0;
    sm_op      = '0;
    sm_idx     = '0;
    sm_rel     = '0;
    host_we    = 1'b0;
    host_re    = 1'b0;
    host_addr  = '0;
    host_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    push("rst_flags", S_FLAGS, 0);
    push("rst_stall", S_STALL, 0);
    push("rst_irq",   S_IRQ,   0);
    push("rst_rdata", S_RDATA, 0);
    tick();
    reset = 1'b1;
    sm_en = 4'hF;

    // INTE0=0x7, INTE1=0x8
    host_wr(2'd1, 32'h87);
    tick();
    idle_inputs();

    // 1: two SET+WAITs
    sm_cmd(0, OP_WAIT, 3'd0, 1'b0);
    sm_cmd(1, OP_WAIT, 3'd1, 1'b0);
    push("t1_req_stall", S_STALL, 4'h3);
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      push("t1_flags", S_FLAGS, 8'h03);
      push("t1_stall", S_STALL, 4'h3);
      push("t1_irq",   S_IRQ,   (i == 0) ? 2'b00 : 2'b01);
      tick();
    end

    // 2: host W1C releases SM1 only
    host_wr(2'd0, 32'h02);
    push("t2_stall_pre", S_STALL, 4'h3);
    tick();
    idle_inputs();
    push("t2_flags", S_FLAGS, 8'h01);
    push("t2_stall_post", S_STALL, 4'h1);
    host_rd(2'd0);
    tick();
    idle_inputs();
    push("t2_rd_flags", S_RDATA, 32'h01);
    push("t2_stall_hold", S_STALL, 4'h1);
    host_rd(2'd3);
    tick();
    idle_inputs();
    push("t2_rd_ints", S_RDATA, 32'h01);
    tick();

    // 3: relative SET beats same-cycle host W1C
    sm_cmd(2, OP_SET, 3'd3, 1'b1);
    host_wr(2'd0, 32'h02);
    push("t3_stall", S_STALL, 4'h1);
    tick();
    idle_inputs();
    push("t3_flags", S_FLAGS, 8'h03);
    host_wr(2'd0, 32'h03);
    tick();
    idle_inputs();
    push("t3_clr_flags", S_FLAGS, 8'h00);
    push("t3_sm0_release", S_STALL, 4'h0);
    tick();

    // 4: SET beats SM CLEAR, then CLEAR alone; relative index with bit 2
    sm_cmd(0, OP_CLR, 3'd5, 1'b0);
    sm_cmd(1, OP_SET, 3'd5, 1'b0);
    tick();
    idle_inputs();
    push("t4_set_wins", S_FLAGS, 8'h20);
    sm_cmd(0, OP_CLR, 3'd5, 1'b0);
    tick();
    idle_inputs();
    push("t4_clear", S_FLAGS, 8'h00);
    sm_cmd(3, OP_SET, 3'd6, 1'b1);
    tick();
    idle_inputs();
    push("t4_rel_hi", S_FLAGS, 8'h20);
    sm_cmd(1, OP_RSVD, 3'd2, 1'b0);
    host_wr(2'd0, 32'h20);
    tick();
    idle_inputs();
    push("t4_rsvd_flags", S_FLAGS, 8'h00);
    push("t4_rsvd_stall", S_STALL, 4'h0);
    tick();

    // 5: forced interrupt on line 1 and host register access
    host_wr(2'd2, 32'h80);
    tick();
    idle_inputs();
    push("t5_irq_lat", S_IRQ, 2'b00);
    tick();
    push("t5_irq1", S_IRQ, 2'b10);
    host_rd(2'd3);
    tick();
    idle_inputs();
    push("t5_rd_ints", S_RDATA, 32'h80);
    host_rd(2'd2);
    tick();
    idle_inputs();
    push("t5_rd_intf", S_RDATA, 32'h80);
    host_rd(2'd1);
    tick();
    idle_inputs();
    push("t5_rd_inte", S_RDATA, 32'h87);
    host_wr(2'd3, 32'hFF);
    tick();
    idle_inputs();
    host_rd(2'd3);
    tick();
    idle_inputs();
    push("t5_ints_ro", S_RDATA, 32'h80);
    host_rd(2'd1);
    host_wr(2'd1, 32'h0F);
    tick();
    idle_inputs();
    push("t5_rw_same", S_RDATA, 32'h87);
    host_rd(2'd1);
    tick();
    idle_inputs();
    push("t5_rd_new_inte", S_RDATA, 32'h0F);
    push("t5_irq_masked", S_IRQ, 2'b00);
    tick();

    // 6: reset mid-WAIT
    sm_cmd(0, OP_WAIT, 3'd0, 1'b0);
    push("t6_req_stall", S_STALL, 4'h1);
    tick();
    idle_inputs();
    push("t6_wait_stall", S_STALL, 4'h1);
    push("t6_flags", S_FLAGS, 8'h01);
    tick();
    push("t6_irq0", S_IRQ, 2'b01);
    push("t6_stall_hold", S_STALL, 4'h1);
    tick();
    reset = 1'b0;
    #1;
    push("t6_rst_flags", S_FLAGS, 0);
    push("t6_rst_stall", S_STALL, 0);
    push("t6_rst_irq",   S_IRQ,   0);
    push("t6_rst_rdata", S_RDATA, 0);
    drain(1'b0);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // sm_en drop inside WAIT
    sm_cmd(1, OP_WAIT, 3'd2, 1'b0);
    push("t6b_req_stall", S_STALL, 4'h2);
    tick();
    idle_inputs();
    push("t6b_wait_stall", S_STALL, 4'h2);
    push("t6b_flags", S_FLAGS, 8'h04);
    tick();
    sm_en = 4'b1101;
    push("t6b_en_drop", S_STALL, 4'h0);
    push("t6b_flag_kept", S_FLAGS, 8'h04);
    tick();
    sm_en = 4'hF;
    push("t6b_stay_idle", S_STALL, 4'h0);
    tick();

    // SET+WAIT on an already-set flag still waits
    sm_cmd(3, OP_WAIT, 3'd2, 1'b0);
    push("t7_req_stall", S_STALL, 4'h8);
    tick();
    idle_inputs();
    push("t7_wait_stall", S_STALL, 4'h8);
    push("t7_flags", S_FLAGS, 8'h04);
    tick();
    host_wr(2'd0, 32'h04);
    push("t7_stall_pre", S_STALL, 4'h8);
    tick();
    idle_inputs();
    push("t7_release", S_STALL, 4'h0);
    push("t7_flags_clr", S_FLAGS, 8'h00);
    tick();

    drain(1'b0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
